// File: rtl/window_fetcher_frame_scheduler.sv
// ---------------------------------------------------------------------------
// window_fetcher_frame_scheduler
//
// Time-shares one window_fetcher between NUM_REQ pixel-stream requesters,
// one whole frame at a time. A round-robin arbiter picks the next requester
// in IDLE. Its pixels are forwarded with raster col/row tags in STREAM. The
// grant is then held in DRAIN until the fetcher reports the frame's last
// window, so two frames never share the fetcher's line buffers.
//
// Optional feature (compile-time macro WF_SCHED_TIMEOUT_EN):
//   When defined, a DRAIN watchdog abandons the drain after DRAIN_TIMEOUT
//   cycles and raises the sticky timeout_o flag. When undefined, DRAIN waits
//   for the last window indefinitely and timeout_o is tied low.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   req_data_i     packed requester pixels, requester n at [n*DATA_WIDTH +: DATA_WIDTH]
//   req_valid_i    per-requester pixel valid
//   req_ready_o    per-requester pixel accept (only the granted one, in STREAM)
//   fetch_data_o   pixel to window_fetcher data_i
//   fetch_col_o    column tag to window_fetcher col_i
//   fetch_row_o    row tag to window_fetcher row_i
//   fetch_valid_o  valid to window_fetcher valid_i
//   fetch_col_i    window column from window_fetcher col_o
//   fetch_row_i    window row from window_fetcher row_o
//   fetch_valid_i  window valid from window_fetcher valid_o
//   grant_o        current or most recent owner, for tagging windows downstream
//   busy_o         high while a frame is streaming or draining
//   frame_done_o   one-cycle pulse after the frame's last window is seen
//   timeout_o      sticky drain-watchdog flag
// ---------------------------------------------------------------------------
module window_fetcher_frame_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int IMAGE_WIDTH   = 5,
  parameter int IMAGE_HEIGHT  = 5,
  parameter int NUM_REQ       = 2,
  parameter int DRAIN_TIMEOUT = 1024,
  localparam int COL_W   = $clog2(IMAGE_WIDTH),
  localparam int ROW_W   = $clog2(IMAGE_HEIGHT),
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fetch_data_o,
  output logic [COL_W-1:0]              fetch_col_o,
  output logic [ROW_W-1:0]              fetch_row_o,
  output logic                          fetch_valid_o,
  input  logic [COL_W-1:0]              fetch_col_i,
  input  logic [ROW_W-1:0]              fetch_row_i,
  input  logic                          fetch_valid_i,
  output logic [GRANT_W-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          timeout_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]            state;
  logic [GRANT_W-1:0]    last;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;

  logic                  pick_found;
  logic [GRANT_W-1:0]    pick_idx;
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  drain_match;
  logic                  drain_expire;
  logic [DATA_WIDTH-1:0] pixel;

  // Round-robin scan starting just after the previous owner, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid_i[(int'(last) + 1 + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = GRANT_W'((int'(last) + 1 + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == ST_STREAM) req_ready_o[grant_o] = 1'b1;
  end

  assign accept      = (state == ST_STREAM) && req_valid_i[grant_o];
  assign pixel       = req_data_i[grant_o*DATA_WIDTH +: DATA_WIDTH];
  assign col_last    = (col == COL_W'(IMAGE_WIDTH - 1));
  assign row_last    = (row == ROW_W'(IMAGE_HEIGHT - 1));
  assign drain_match = fetch_valid_i
                    && (fetch_col_i == COL_W'(IMAGE_WIDTH - 1))
                    && (fetch_row_i == ROW_W'(IMAGE_HEIGHT - 1));
  assign busy_o      = (state != ST_IDLE);

`ifdef WF_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  logic [TO_W-1:0] drain_cnt;

  // The counter sits at zero outside DRAIN, so the first DRAIN cycle counts 0
  // and the watchdog fires on the DRAIN_TIMEOUT-th cycle without a match.
  assign drain_expire = (state == ST_DRAIN) && !drain_match
                     && (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                   drain_cnt <= '0;
      if (drain_expire) timeout_o <= 1'b1;
    end
  end
`else
  assign drain_expire = 1'b0;
  // Watchdog compiled out: DRAIN_TIMEOUT has no effect and the flag never rises.
  assign timeout_o    = (DRAIN_TIMEOUT < 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      grant_o       <= '0;
      last          <= GRANT_W'(NUM_REQ - 1);
      col           <= '0;
      row           <= '0;
      fetch_data_o  <= '0;
      fetch_col_o   <= '0;
      fetch_row_o   <= '0;
      fetch_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      fetch_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_o <= pick_idx;
            last    <= pick_idx;
            state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            fetch_valid_o <= 1'b1;
            fetch_data_o  <= pixel;
            fetch_col_o   <= col;
            fetch_row_o   <= row;
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= ST_DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_match) begin
            frame_done_o <= 1'b1;
            state        <= ST_IDLE;
          end else if (drain_expire) begin
            // Abandon the drain silently; the pointer already moved at grant.
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/window_fetcher_frame_scheduler.md
Name: window_fetcher_frame_scheduler

Overview:
Shares a single window_fetcher instance between NUM_REQ pixel-stream requesters at frame granularity. It grants one requester per frame using round-robin arbitration and generates raster col/row coordinates for that requester's pixels. It forwards the pixels to the fetcher, then holds the grant until the fetcher has emitted the frame's last window, so frames never interleave inside the fetcher's line buffers. It sits directly upstream of window_fetcher and also observes the fetcher's output side.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMAGE_WIDTH, 5, frame columns (>=2)
IMAGE_HEIGHT, 5, frame rows (>=2)
NUM_REQ, 2, number of requesters (1..8)
DRAIN_TIMEOUT, 1024, drain watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_data_i  in  NUM_REQ*DATA_WIDTH  packed pixels; requester n occupies bits [n*DATA_WIDTH +: DATA_WIDTH]
req_valid_i  in  NUM_REQ  per-requester pixel valid
req_ready_o  out  NUM_REQ  per-requester pixel accept
fetch_data_o  out  DATA_WIDTH  pixel to window_fetcher data_i
fetch_col_o  out  $clog2(IMAGE_WIDTH)  to window_fetcher col_i
fetch_row_o  out  $clog2(IMAGE_HEIGHT)  to window_fetcher row_i
fetch_valid_o  out  1  to window_fetcher valid_i
fetch_col_i  in  $clog2(IMAGE_WIDTH)  from window_fetcher col_o
fetch_row_i  in  $clog2(IMAGE_HEIGHT)  from window_fetcher row_o
fetch_valid_i  in  1  from window_fetcher valid_o
grant_o  out  $clog2(NUM_REQ) (min 1)  current or last owner, for tagging windows downstream
busy_o  out  1  high in STREAM or DRAIN
frame_done_o  out  1  one-cycle pulse when a frame fully drains
timeout_o  out  1  sticky drain-timeout flag

Behaviour:
- Reset values: all outputs 0. State=IDLE. col/row counters 0. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- States and transitions:
  - IDLE: scan req_valid_i starting at (last+1) mod NUM_REQ and wrapping. On the first set bit n: grant_o<=n, last<=n, go to STREAM. If no bit is set, stay in IDLE. req_ready_o=0 in IDLE. Arbitration costs 1 cycle.
  - STREAM: req_ready_o[grant_o]=1 (combinational on state and grant); all other ready bits are 0.
    - On accept (valid & ready): fetch_data_o, fetch_col_o and fetch_row_o are registered from the data and the current counters, and fetch_valid_o=1 the next cycle. Otherwise fetch_valid_o=0 next cycle.
    - Input-to-fetcher latency is 1 cycle.
    - Counters: col++ per accept. At col==IMAGE_WIDTH-1, col<=0 and row++.
    - Accept at col==IMAGE_WIDTH-1 and row==IMAGE_HEIGHT-1: row<=0, go to DRAIN. Ready drops in the same cycle the state changes.
    - Bubbles (valid low) are allowed mid-frame; counters hold.
  - DRAIN: req_ready_o=0.
    - Exit when fetch_valid_i=1, fetch_col_i==IMAGE_WIDTH-1 and fetch_row_i==IMAGE_HEIGHT-1.
    - On exit: frame_done_o=1 for that cycle (registered, so it is visible the following cycle), go to IDLE.
    - Fetcher output windows seen in STREAM or DRAIN are not inspected except for this exit match.
- fetch_valid_i during IDLE is ignored.
- grant_o holds its value in IDLE until the next grant.
- busy_o = (state != IDLE).
- Simultaneous events:
  - All requesters valid in IDLE: round-robin gives fairness. With NUM_REQ=2 and both valid continuously, grants alternate 0,1,0,1.
  - A drain-exit match in the same cycle as new req_valid_i: DRAIN->IDLE first, arbitration on the next cycle. There is no DRAIN->STREAM shortcut.
- Reset mid-operation: returns to IDLE with counters and pointer at reset values. The partial frame is abandoned, and the fetcher is reset by the same rst_i.
- Counter widths use $clog2. IMAGE_WIDTH and IMAGE_HEIGHT need not be powers of two; wrap is by compare, not overflow.

Optional Feature:
WF_SCHED_TIMEOUT_EN:
- Defined: a DRAIN cycle counter, width $clog2(DRAIN_TIMEOUT+1), clears on entry to DRAIN. If it reaches DRAIN_TIMEOUT without an exit match:
  - go to IDLE
  - timeout_o<=1, sticky until rst_i
  - no frame_done_o pulse
  - the round-robin pointer still advances
- Undefined: no counter; timeout_o tied 0; DRAIN waits indefinitely.

Test Plan:
- Single frame (NUM_REQ=2, W=H=5): req0 streams 25 pixels (values 0..24) with no bubbles.
  -> fetch_valid_o high 25 cycles, starting 2 cycles after req_valid_i.
  -> col/row follow the raster (0,0)..(4,4).
  -> frame_done_o pulses once after the fetcher emits window (4,4).
  -> Scoreboard against WindowFetcherModel matches.
- Contention: req0 and req1 are both valid from reset, with 3 frames each.
  -> grant_o sequence 0,1,0,1,0,1.
  -> req_ready_o never high for both requesters.
  -> No req1 pixel enters before frame_done_o of the preceding req0 frame.
- Bubbles: req0 drops valid every 3rd cycle.
  -> Counters hold during bubbles.
  -> Exactly 25 accepted pixels per frame; coordinates are unchanged versus the no-bubble case.
- Drain blocking: req1 asserts valid during req0's DRAIN.
  -> req_ready_o[1]=0 until the cycle after frame_done_o plus 1 arbitration cycle.
- Reset mid-frame: rst_i asserted after 12 accepted pixels.
  -> Next cycle: all outputs 0, state IDLE.
  -> The next frame starts at (0,0) with grant 0.
- With WF_SCHED_TIMEOUT_EN and DRAIN_TIMEOUT=16: hold fetch_valid_i=0 after the frame.
  -> timeout_o rises 16 cycles into DRAIN; busy_o falls; no frame_done_o.
  -> timeout_o stays 1 until rst_i.
